muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit holding the HI/LO special registers. It is the sequential successor to the combinational mult/div path and the two-entry special register file. It sits beside the ALU in the MIPS datapath. It accepts signed or unsigned MULT/DIV operations through a start/busy/done handshake, and it supports MTHI/MTLO writes and continuous HI/LO reads for MFHI/MFLO.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits. `WIDTH` must be ≥4 and even.
- `clk` input 1: clock, all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request a new operation. Sampled only in IDLE.
- `op` input 2: operation code. 00 = MULT (signed), 01 = MULTU, 10 = DIV (signed), 11 = DIVU.
- `a` input WIDTH: multiplicand or dividend. Captured when `start` is accepted.
- `b` input WIDTH: multiplier or divisor. Captured when `start` is accepted.
- `mthi` input 1: write `wdata` to HI. Honoured only in IDLE.
- `mtlo` input 1: write `wdata` to LO. Honoured only in IDLE.
- `wdata` input WIDTH: write data for MTHI/MTLO.
- `busy` output 1: high while in CALC or FIX.
- `done` output 1: one-cycle pulse in the cycle after results land in HI/LO.
- `divzero` output 1: set with `done` when a DIV/DIVU had `b`=0. Held until the next accepted start.
- `hi` output WIDTH: HI register, combinationally visible.
- `lo` output WIDTH: LO register, combinationally visible.

## Operation
- There are three states: IDLE, CALC and FIX.
- **IDLE → CALC** when `start`=1.
  - The unit latches `op`, the magnitudes |a| and |b|, and the result signs.
  - For unsigned ops the operands are used as-is and the signs are 0.
  - An iteration counter is loaded with `WIDTH`.
- **CALC** performs one radix-2 step per cycle. After `WIDTH` steps it moves to FIX.
  - Multiply: shift-add over magnitudes into a 2·WIDTH accumulator.
  - Divide: restoring division. Each step shifts the remainder left, trial-subtracts the divisor, and shifts the quotient bit in.
- **FIX** applies the sign fixup and writes HI/LO, then returns to IDLE. It always takes one cycle.
  - MULT: the {HI,LO} product is negated if the signs differ.
  - DIV: LO = quotient, negated if sign(a)≠sign(b). HI = remainder, negated if a<0. The remainder carries the dividend's sign.
  - DIVU/MULTU: no negation.
- **Division by zero** runs the same latency. The result is HI = `a` as captured, LO = all ones, and `divzero`=1.
- **Signed DIV of the most-negative value by −1**: LO = most-negative (wraps), HI = 0. No flag is raised.
- **Signed MULT of most-negative × most-negative** gives the exact 2·WIDTH result: HI=0x40000000, LO=0 at WIDTH 32.
- `start` while busy is ignored. There is no queueing, and the operation in flight is unaffected.
- `mthi`/`mtlo` while busy are ignored.
- In IDLE, `mthi` and `mtlo` may both be high in the same cycle; both registers take `wdata`.
- In IDLE, `start` with `mthi` or `mtlo` in the same cycle: `start` wins and the writes are dropped.
- HI/LO hold their values between operations and while CALC runs. They change only at the FIX edge or on an IDLE MTHI/MTLO edge.

## Timing
- **Reset** (asynchronous, `reset`=0): state goes to IDLE. `hi`, `lo`, `busy`, `done` and `divzero` all go to 0. The counter and datapath registers are cleared.
  - An operation in flight when reset asserts is abandoned and produces no `done`.
  - After reset deasserts, the first rising edge may accept `start`.
- **Operation timeline**, where the `start` accept edge is E0:
  - `busy`=1 from after E0.
  - Edges E1..E_WIDTH are CALC steps.
  - Edge E_WIDTH+1 is FIX: `hi`/`lo` update and `done`=1 for exactly one cycle.
  - `busy`=0 after E_WIDTH+1.
  - Total latency is WIDTH+1 cycles, which is 33 at the default. It is constant for all ops and operands.
- **Back-to-back operations**: `start` may be high in the `done` cycle and is accepted at that edge.
- **MTHI/MTLO**: the register updates at the sampling edge and is visible the next cycle.

## Test plan
- **MULT**: a=0xFFFFFFFD (−3), b=5 → after 33 cycles `done`=1, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1, `divzero`=0.
- **MULTU and DIVU**:
  - MULTU a=b=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
  - DIVU a=100, b=7 → `lo`=14, `hi`=2.
- **Signed DIV**:
  - a=−7, b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Divide by zero**: DIV a=42, b=0 → `done` after 33 cycles, `hi`=42, `lo`=0xFFFFFFFF, `divzero`=1. The next accepted start clears `divzero`.
- **Ignored inputs while busy**: start MULT 6×7, then pulse `start` with different operands and `mthi`/`mtlo` with `wdata`=0x1234 mid-CALC.
  - Expect a single `done`, `lo`=42, `hi`=0.
  - In IDLE, `mtlo` with `wdata`=0x1234 → `lo`=0x1234 the next cycle.
- **Reset mid-operation**: assert `reset`=0 at cycle 10 of a DIVU.
  - `busy`, `hi`, `lo` and `done` go to 0 immediately, and no `done` follows.
  - A new MULTU 3×4 started after release gives `lo`=12.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit that owns the HI/LO special registers.
// A MULT/DIV takes WIDTH CALC steps plus one FIX cycle, whatever the operands.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_mthi,
    input  logic             i_mtlo,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_divzero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_a_raw;
    logic               r_b_zero;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_done;
    logic               r_divzero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_in_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_fits;
    logic [WIDTH:0]     w_rem_new;
    logic [2*WIDTH-1:0] w_div_step;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    always_comb begin
        w_in_signed = ~i_op[0];
        w_a_neg     = w_in_signed & i_a[WIDTH-1];
        w_b_neg     = w_in_signed & i_b[WIDTH-1];
        w_mag_a     = w_a_neg ? -i_a : i_a;
        w_mag_b     = w_b_neg ? -i_b : i_b;
    end

    // Multiply: r_opnd is the multiplicand; the multiplier is consumed from acc[0].
    // Divide: r_opnd is the divisor; acc = {remainder, dividend/quotient}.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};
        w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_fits     = (w_rem_sh >= {1'b0, r_opnd});
        w_rem_new  = w_fits ? (w_rem_sh - {1'b0, r_opnd}) : w_rem_sh;
        w_div_step = {w_rem_new[WIDTH-1:0], r_acc[WIDTH-2:0], w_fits};
    end

    always_comb begin
        w_prod_fix = r_neg_res ? -r_acc : r_acc;
        w_fix_hi   = w_prod_fix[2*WIDTH-1:WIDTH];
        w_fix_lo   = w_prod_fix[WIDTH-1:0];
        if (r_op[1]) begin
            if (r_b_zero) begin
                w_fix_hi = r_a_raw;
                w_fix_lo = '1;
            end else begin
                w_fix_hi = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
                w_fix_lo = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = S_CALC;
            S_CALC:  if (r_cnt == CW'(1)) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_opnd    <= '0;
            r_a_raw   <= '0;
            r_b_zero  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_acc     <= '0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= (r_state == S_FIX);
            case (r_state)
                S_IDLE: begin
                    // start takes priority: MTHI/MTLO in the same cycle are dropped
                    if (i_start) begin
                        r_op      <= i_op;
                        r_opnd    <= i_op[1] ? w_mag_b : w_mag_a;
                        r_acc     <= {{WIDTH{1'b0}}, (i_op[1] ? w_mag_a : w_mag_b)};
                        r_a_raw   <= i_a;
                        r_b_zero  <= (i_b == '0);
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_cnt     <= CW'(WIDTH);
                        r_divzero <= 1'b0;
                    end else begin
                        if (i_mthi) r_hi <= i_wdata;
                        if (i_mtlo) r_lo <= i_wdata;
                    end
                end
                S_CALC: begin
                    r_acc <= r_op[1] ? w_div_step : w_mul_step;
                    r_cnt <= r_cnt - 1'b1;
                end
                S_FIX: begin
                    r_hi      <= w_fix_hi;
                    r_lo      <= w_fix_lo;
                    r_divzero <= r_op[1] & r_b_zero;
                end
                default: ;
            endcase
        end
    end

    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = r_done;
    assign o_divzero = r_divzero;
    assign o_hi      = r_hi;
    assign o_lo      = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         divzero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
        .i_a(a), .i_b(b), .i_mthi(mthi), .i_mtlo(mtlo), .i_wdata(wdata),
        .o_busy(busy), .o_done(done), .o_divzero(divzero), .o_hi(hi), .o_lo(lo)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_model(input logic [1:0] f_op, input logic [31:0] f_a,
                                      input logic [31:0] f_b, output logic [31:0] f_hi,
                                      output logic [31:0] f_lo, output logic f_dz);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa   = $signed(f_a);
        sb   = $signed(f_b);
        f_dz = 1'b0;
        p    = '0;
        case (f_op)
            2'b00: p = 64'(sa * sb);
            2'b01: p = {32'b0, f_a} * {32'b0, f_b};
            default: ;
        endcase
        f_hi = p[63:32];
        f_lo = p[31:0];
        if (f_op[1]) begin
            if (f_b == 0) begin
                f_hi = f_a;
                f_lo = '1;
                f_dz = 1'b1;
            end else if (f_op == 2'b10) begin
                q    = sa / sb;
                r    = sa % sb;
                f_lo = 32'(q);
                f_hi = 32'(r);
            end else begin
                f_lo = f_a / f_b;
                f_hi = f_a % f_b;
            end
        end
    endfunction

    // Waits for done, bounded; returns the number of edges after the accept edge.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] t_op,
                          input logic [31:0] t_a, input logic [31:0] t_b);
        logic [31:0] e_hi, e_lo;
        logic        e_dz;
        int          cyc;
        ref_model(t_op, t_a, t_b, e_hi, e_lo, e_dz);
        @(negedge clk);
        start = 1'b1; op = t_op; a = t_a; b = t_b;
        @(posedge clk); #1;
        start = 1'b0;
        check_val({tag, "_busy"}, 64'(busy), 64'(1));
        check_val({tag, "_dzclr"}, 64'(divzero), 64'(0));
        wait_done(cyc);
        check_val({tag, "_lat"}, 64'(cyc), 64'(W + 1));
        check_val({tag, "_hi"}, 64'(hi), 64'(e_hi));
        check_val({tag, "_lo"}, 64'(lo), 64'(e_lo));
        check_val({tag, "_dz"}, 64'(divzero), 64'(e_dz));
        $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0b (exp hi=%h lo=%h dz=%0b) lat=%0d",
                 tag, t_op, t_a, t_b, hi, lo, divzero, e_hi, e_lo, e_dz, cyc);
    endtask

    function automatic logic [31:0] pick_val(input bit allow_zero);
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return allow_zero ? 32'h0 : 32'h1;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          n_done, cyc;
        logic [31:0] save_hi, save_lo;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        #1;
        check_val("rst_busy", 64'(busy), 64'(0));
        check_val("rst_done", 64'(done), 64'(0));
        check_val("rst_dz", 64'(divzero), 64'(0));
        check_val("rst_hi", 64'(hi), 64'(0));
        check_val("rst_lo", 64'(lo), 64'(0));
        @(negedge clk); rst_n = 1'b1;

        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("divu", 2'b11, 32'd100, 32'd7);
        run_op("div_neg", 2'b10, -32'd7, 32'd2);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000);
        run_op("div_zero", 2'b10, 32'd42, 32'd0);
        run_op("divu_zero", 2'b11, 32'hDEAD_BEEF, 32'd0);
        run_op("multu_b2b", 2'b01, 32'd9, 32'd9);

        // start/mthi/mtlo pulsed mid-CALC must be ignored
        save_hi = hi; save_lo = lo;
        @(negedge clk); start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd99; b = 32'd3;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234;
        @(negedge clk); start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check_val("busy_hi_hold", 64'(hi), 64'(save_hi));
        check_val("busy_lo_hold", 64'(lo), 64'(save_lo));
        n_done = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                save_hi = hi; save_lo = lo;
            end
        end
        check_val("ign_ndone", 64'(n_done), 64'(1));
        check_val("ign_lo", 64'(save_lo), 64'(42));
        check_val("ign_hi", 64'(save_hi), 64'(0));
        $display("ignore_busy dones=%0d hi=%h lo=%h", n_done, save_hi, save_lo);

        @(negedge clk); mtlo = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1; mtlo = 1'b0;
        check_val("mtlo_lo", 64'(lo), 64'(32'h1234));
        check_val("mtlo_hi", 64'(hi), 64'(0));
        @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'hABCD;
        @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
        check_val("mtboth_hi", 64'(hi), 64'(32'hABCD));
        check_val("mtboth_lo", 64'(lo), 64'(32'hABCD));
        $display("mthi/mtlo hi=%h lo=%h", hi, lo);

        // start wins over a same-cycle MTHI
        @(negedge clk); start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
        mthi = 1'b1; wdata = 32'h5555;
        @(posedge clk); #1; start = 1'b0; mthi = 1'b0;
        check_val("startwin_hi", 64'(hi), 64'(32'hABCD));
        wait_done(cyc);
        check_val("startwin_lat", 64'(cyc), 64'(W + 1));
        check_val("startwin_lo", 64'(lo), 64'(6));
        check_val("startwin_res_hi", 64'(hi), 64'(0));
        $display("start_vs_mthi hi=%h lo=%h", hi, lo);

        // asynchronous reset in the middle of a DIVU
        @(negedge clk); start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); rst_n = 1'b0; #1;
        check_val("arst_busy", 64'(busy), 64'(0));
        check_val("arst_hi", 64'(hi), 64'(0));
        check_val("arst_lo", 64'(lo), 64'(0));
        check_val("arst_done", 64'(done), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check_val("arst_nodone", 64'(n_done), 64'(0));
        $display("reset_mid_op dones_after=%0d", n_done);
        run_op("multu_post_rst", 2'b01, 32'd3, 32'd4);

        for (int i = 0; i < 150; i++) begin
            logic [1:0]  r_op;
            logic [31:0] r_a, r_b;
            r_op = 2'($urandom_range(0, 3));
            r_a  = pick_val(1'b1);
            r_b  = pick_val($urandom_range(0, 3) == 0);
            run_op("rand", r_op, r_a, r_b);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
